nixie_scan_controller: RTL

//  Time-multiplexes the six Nixie tubes: drives one tube at a time from a

---
 rtl/nixie_scan_controller.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/nixie_scan_controller.sv
// nixie_scan_controller
//   Time-multiplexes six Nixie tubes from a latched 6-digit BCD frame. Each
//   tube slot is a blanking gap (all anodes off, value already set up for the
//   slot) followed by a drive window. New display data is double-buffered and
//   only swapped in at the frame boundary (entry to slot-0 blanking).
//
//   Optional feature macro: NIXIE_BLINK_EN (cursor tube blinking).
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   digits       BCD digits, tube i uses digits[4i+3:4i]
//   dots         decimal-point request per tube
//   tubeMask     1 = tube allowed to light
//   load         1-cycle strobe capturing digits/dots/tubeMask
//   cursor       tube index to blink (>=6 = none), blink build only
//   blinkEnable  enables cursor blinking, blink build only
//   frameStart   1-cycle pulse on first blanking cycle of slot 0
//   nixieEnable  one-hot anode enable, active high
//   nixieValue   {3'b0, dot, bcd} for the current/upcoming slot

module nixie_scan_controller #(
    parameter int unsigned ON_CYCLES    = 100000,
    parameter int unsigned BLANK_CYCLES = 10000,
    parameter int unsigned BLINK_FRAMES = 76
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] digits,
    input  logic [5:0]  dots,
    input  logic [5:0]  tubeMask,
    input  logic        load,
    input  logic [2:0]  cursor,
    input  logic        blinkEnable,
    output logic        frameStart,
    output logic [5:0]  nixieEnable,
    output logic [7:0]  nixieValue
);

    localparam int unsigned NUM_TUBES = 6;
    localparam int unsigned DIG_W     = 4 * NUM_TUBES;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned VAL_W     = 8;
    localparam int unsigned MAX_CYC   = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W     = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic {
        ST_BLANK,
        ST_DRIVE
    } state_e;

    // Scan FSM state
    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    // Display buffers
    logic [DIG_W-1:0]       pend_dig_q, pend_dig_d;
    logic [NUM_TUBES-1:0]   pend_dots_q, pend_dots_d;
    logic [NUM_TUBES-1:0]   pend_mask_q, pend_mask_d;
    logic                   pend_valid_q, pend_valid_d;
    logic [DIG_W-1:0]       act_dig_q, act_dig_d;
    logic [NUM_TUBES-1:0]   act_dots_q, act_dots_d;
    logic [NUM_TUBES-1:0]   act_mask_q, act_mask_d;

    // Registered outputs
    logic                   frame_start_q, frame_start_d;
    logic [NUM_TUBES-1:0]   nixie_enable_q, nixie_enable_d;
    logic [VAL_W-1:0]       nixie_value_q, nixie_value_d;

    logic                   boundary_c;
    logic [3:0]             cur_bcd_c;
    logic                   cur_dot_c;
    logic                   cur_mask_c;
    logic                   blink_off_c;

    // Current cycle is blanking cycle 0 of slot 0
    assign boundary_c = (state_q == ST_BLANK) && (idx_q == '0) && (cnt_q == '0);

    // Scan sequencing: BLANK -> DRIVE -> BLANK of next slot
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + CNT_W'(1);
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
                    state_d = ST_DRIVE;
                    cnt_d   = '0;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == CNT_W'(ON_CYCLES - 1)) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_W'(NUM_TUBES - 1)) ? '0 : idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = ST_BLANK;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Double buffer; a load on the boundary cycle bypasses pending
    always_comb begin
        pend_dig_d   = pend_dig_q;
        pend_dots_d  = pend_dots_q;
        pend_mask_d  = pend_mask_q;
        pend_valid_d = pend_valid_q;
        act_dig_d    = act_dig_q;
        act_dots_d   = act_dots_q;
        act_mask_d   = act_mask_q;
        if (boundary_c) begin
            pend_valid_d = 1'b0;
            if (load) begin
                act_dig_d  = digits;
                act_dots_d = dots;
                act_mask_d = tubeMask;
            end else if (pend_valid_q) begin
                act_dig_d  = pend_dig_q;
                act_dots_d = pend_dots_q;
                act_mask_d = pend_mask_q;
            end
        end else if (load) begin
            pend_dig_d   = digits;
            pend_dots_d  = dots;
            pend_mask_d  = tubeMask;
            pend_valid_d = 1'b1;
        end
    end

    // Select active data for the slot addressed by idx
    always_comb begin
        cur_bcd_c  = '0;
        cur_dot_c  = 1'b0;
        cur_mask_c = 1'b0;
        for (int i = 0; i < NUM_TUBES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_bcd_c  = act_dig_d[4*i +: 4];
                cur_dot_c  = act_dots_d[i];
                cur_mask_c = act_mask_d[i];
            end
        end
    end

`ifdef NIXIE_BLINK_EN
    localparam int unsigned BF_W = $clog2(BLINK_FRAMES + 1);

    logic            blink_phase_q, blink_phase_d;
    logic [BF_W-1:0] blink_cnt_q, blink_cnt_d;

    // Count frame starts; phase flips once BLINK_FRAMES frames have elapsed
    always_comb begin
        blink_phase_d = blink_phase_q;
        blink_cnt_d   = blink_cnt_q;
        if (boundary_c) begin
            if (blink_cnt_q == BF_W'(BLINK_FRAMES)) begin
                blink_phase_d = ~blink_phase_q;
                blink_cnt_d   = BF_W'(1);
            end else begin
                blink_cnt_d = blink_cnt_q + BF_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_phase_q <= 1'b0;
            blink_cnt_q   <= '0;
        end else begin
            blink_phase_q <= blink_phase_d;
            blink_cnt_q   <= blink_cnt_d;
        end
    end

    // cursor >= 6 never matches a slot index
    assign blink_off_c = blink_phase_d && blinkEnable && (cursor == idx_q);
`else
    logic unused_blink;
    assign unused_blink = ^{cursor, blinkEnable, 32'(BLINK_FRAMES)};
    assign blink_off_c  = 1'b0;
`endif

    // Output registers reflect the current scan position
    always_comb begin
        frame_start_d  = boundary_c;
        nixie_value_d  = {3'b000, cur_dot_c, cur_bcd_c};
        nixie_enable_d = '0;
        if ((state_q == ST_DRIVE) && (cur_bcd_c <= 4'd9) && cur_mask_c && !blink_off_c) begin
            nixie_enable_d = NUM_TUBES'(1) << idx_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_BLANK;
            idx_q          <= '0;
            cnt_q          <= '0;
            pend_dig_q     <= '0;
            pend_dots_q    <= '0;
            pend_mask_q    <= '0;
            pend_valid_q   <= 1'b0;
            act_dig_q      <= '0;
            act_dots_q     <= '0;
            act_mask_q     <= '0;
            frame_start_q  <= 1'b0;
            nixie_enable_q <= '0;
            nixie_value_q  <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            pend_dig_q     <= pend_dig_d;
            pend_dots_q    <= pend_dots_d;
            pend_mask_q    <= pend_mask_d;
            pend_valid_q   <= pend_valid_d;
            act_dig_q      <= act_dig_d;
            act_dots_q     <= act_dots_d;
            act_mask_q     <= act_mask_d;
            frame_start_q  <= frame_start_d;
            nixie_enable_q <= nixie_enable_d;
            nixie_value_q  <= nixie_value_d;
        end
    end

    assign frameStart  = frame_start_q;
    assign nixieEnable = nixie_enable_q;
    assign nixieValue  = nixie_value_q;

endmodule
